// File: rtl/bcd_pkg.sv
// Shared types and defaults for the binary-to-BCD display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int BIN_W_DEF  = 16;
  localparam int DIGITS_DEF = 5;

  // Constant 10**n, wide enough to compare against 2**BIN_W for any
  // practical display width during elaboration.
  function automatic logic [127:0] pow10(input int n);
    logic [127:0] acc;
    acc = 128'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 128'd10;
    end
    return acc;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Latency: combinational.
// Backpressure: none.
// Ports: din  - scratch digit before correction
//        dout - corrected digit (din >= 5 ? din + 3 : din)
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  input  logic               unused_tie,
  output logic [DIGIT_W-1:0] dout
);

  // unused_tie is held at 0 by the parent; folding it in
  // keeps every input observable.
  always_comb begin
    dout = din;
    if ((din >= DIGIT_W'(5)) && !unused_tie) begin
      dout = din + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter from a binary count to packed BCD.
// Latency: start accepted on edge T -> bcd/done/blank registered on edge T+BIN_W+1.
// Backpressure: start is taken only in IDLE; starts while busy are dropped.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   start  - conversion request, sampled only in IDLE
//   bin    - binary input, captured on the accepted start edge
//   busy   - high in SHIFT and DONE
//   done   - one-cycle pulse coincident with bcd update
//   bcd    - packed BCD result, digit 0 in [3:0], held between conversions
//   valid  - sticky, set on first done, cleared only by reset
//   blank  - leading-zero mask; driven only when BCD_LEADING_ZERO_BLANK_EN
//            is defined, otherwise tied to zero
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                    valid,
  output logic [DIGITS-1:0]       blank
);

  localparam int SCR_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int CAT_W = SCR_W + BIN_W;

  // The digit count must be able to hold the largest input value.
  if (pow10(DIGITS) <= ((128'd1 << BIN_W) - 128'd1)) begin : g_bad_size
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  state_t             state_q, state_nxt;
  logic [BIN_W-1:0]   shift_q;
  logic [SCR_W-1:0]   scratch_q;
  logic [CNT_W-1:0]   count_q;
  logic [SCR_W-1:0]   bcd_q;
  logic               done_q;
  logic               valid_q;
  logic               accept;
  logic [SCR_W-1:0]   corr;
  logic [CAT_W-1:0]   cat_shifted;

  // One correction stage per digit, reused on every shift cycle.
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .din        (scratch_q[i*DIGIT_W +: DIGIT_W]),
      .unused_tie (1'b0),
      .dout       (corr[i*DIGIT_W +: DIGIT_W])
    );
  end

  // Shift the corrected scratch and the input together; the bit leaving the
  // top digit falls off the end and is always zero for a legal sizing.
  assign cat_shifted = {corr, shift_q} << 1;

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (count_q == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      done_q  <= 1'b0;
      if (accept) begin
        shift_q   <= bin;
        scratch_q <= '0;
        count_q   <= CNT_W'(BIN_W);
      end
      if (state_q == SHIFT) begin
        scratch_q <= cat_shifted[CAT_W-1:BIN_W];
        shift_q   <= cat_shifted[BIN_W-1:0];
        count_q   <= count_q - CNT_W'(1);
      end
      if (state_q == DONE) begin
        bcd_q   <= scratch_q;
        done_q  <= 1'b1;
        valid_q <= 1'b1;
      end
    end
  end

  assign busy  = (state_q == SHIFT) || (state_q == DONE);
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign valid = valid_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_nxt;
  logic              seen_nz;

  // Walk down from the top digit; every digit above the first nonzero one
  // is blanked. Digit 0 always shows so a zero value displays "0".
  always_comb begin
    blank_nxt = '0;
    seen_nz   = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (scratch_q[i*DIGIT_W +: DIGIT_W] != '0) begin
        seen_nz = 1'b1;
      end
      blank_nxt[i] = !seen_nz;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_q <= '0;
    end else if (state_q == DONE) begin
      blank_q <= blank_nxt;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: table of conversions plus handshake,
// abort and free-running sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic        valid;
  logic [4:0]  blank;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .valid (valid),
    .blank (blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin_v;
    logic [19:0] exp_bcd;
    logic [4:0]  exp_blank;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_blk(input logic [4:0] b);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    return b;
`else
    return (b & 5'b00000);
`endif
  endfunction

  // Counts negedges until done is seen; -1 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
      if (n >= 40) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic convert(input logic [15:0] v, input logic [19:0] exp_bcd,
                         input logic [4:0] exp_blank, input string tag);
    int n;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = 16'hA5A5;
    check({tag, "_busy_t1"}, 32'(busy), 32'd1);
    check({tag, "_done_t1"}, 32'(done), 32'd0);
    wait_done(n);
    check({tag, "_latency"}, 32'(n), 32'd17);
    check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_blank"}, 32'(blank), 32'(exp_blk(exp_blank)));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int extra_done;

    vecs[0] = '{16'd0,     20'h00000, 5'b11110};
    vecs[1] = '{16'd65535, 20'h65535, 5'b00000};
    vecs[2] = '{16'd1234,  20'h01234, 5'b10000};
    vecs[3] = '{16'd42,    20'h00042, 5'b11100};
    vecs[4] = '{16'd9,     20'h00009, 5'b11110};
    vecs[5] = '{16'd10,    20'h00010, 5'b11100};
    vecs[6] = '{16'd100,   20'h00100, 5'b11000};
    vecs[7] = '{16'd59999, 20'h59999, 5'b00000};
    vecs[8] = '{16'd1000,  20'h01000, 5'b10000};

    reset = 1'b1;
    start = 1'b0;
    bin   = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_bcd",   32'(bcd),   32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_blank", 32'(blank), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      convert(vecs[i].bin_v, vecs[i].exp_bcd, vecs[i].exp_blank, $sformatf("vec%0d", i));
    end

    // Second start while busy is dropped; no extra done afterwards.
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd500;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 16'd999;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ign_found", 32'(n > 0), 32'd1);
    check("ign_bcd", 32'(bcd), 32'h00500);
    extra_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
    end
    check("ign_no_second_done", 32'(extra_done), 32'd0);
    check("ign_idle", 32'(busy), 32'd0);

    // Reset mid-conversion aborts immediately.
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd777;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_bcd",   32'(bcd),   32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_publish", 32'(bcd), 32'd0);
    convert(16'd1234, 20'h01234, 5'b10000, "post_abort");

    // Free-running: start held high, bin stepped after each done.
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd9;
    wait_done(n);
    check("free0_period", 32'(n), 32'd18);
    check("free0_bcd", 32'(bcd), 32'h00009);
    bin = 16'd10;
    wait_done(n);
    check("free1_period", 32'(n), 32'd18);
    check("free1_bcd", 32'(bcd), 32'h00010);
    bin = 16'd11;
    wait_done(n);
    check("free2_period", 32'(n), 32'd18);
    check("free2_bcd", 32'(bcd), 32'h00011);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("free_stop_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
